// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and constants for the USB full-speed TX sequencer
package usb_tx_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_DATA0 = 3'd1,
        CMD_DATA1 = 3'd2,
        CMD_ACK   = 3'd3,
        CMD_NAK   = 3'd4,
        CMD_STALL = 3'd5,
        CMD_RSV6  = 3'd6,
        CMD_RSV7  = 3'd7
    } tx_cmd_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP,
        ST_DONE,
        ST_ERROR,
        ST_WAIT_CLR
    } tx_state_t;

    localparam logic [7:0]  SYNC_BYTE       = 8'h80;
    localparam logic [7:0]  PID_DATA0       = 8'hC3;
    localparam logic [7:0]  PID_DATA1       = 8'h4B;
    localparam logic [7:0]  PID_ACK         = 8'hD2;
    localparam logic [7:0]  PID_NAK         = 8'h5A;
    localparam logic [7:0]  PID_STALL       = 8'h1E;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    function automatic logic is_data_cmd(input tx_cmd_t cmd);
        return (cmd == CMD_DATA0) || (cmd == CMD_DATA1);
    endfunction

    function automatic logic is_invalid_cmd(input tx_cmd_t cmd);
        return (cmd == CMD_RSV6) || (cmd == CMD_RSV7);
    endfunction

    // PID byte already carries its check nibble, so it goes out unchanged
    function automatic logic [7:0] pid_byte(input tx_cmd_t cmd);
        case (cmd)
            CMD_DATA0: return PID_DATA0;
            CMD_DATA1: return PID_DATA1;
            CMD_ACK:   return PID_ACK;
            CMD_NAK:   return PID_NAK;
            CMD_STALL: return PID_STALL;
            default:   return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - CRC-16/USB accumulator folding one byte per cycle, LSB first
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] r_crc;
    logic [15:0] w_fold;

    // Eight reflected shift steps unrolled so a whole byte folds in one clock
    always_comb begin
        w_fold = r_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_fold[0] ^ data[i]) begin
                w_fold = (w_fold >> 1) ^ CRC16_POLY_REFL;
            end else begin
                w_fold = w_fold >> 1;
            end
        end
    end

    // Running remainder; clear wins over enable so a new packet always starts from the seed
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_crc <= CRC16_INIT;
        end else if (clear) begin
            r_crc <= CRC16_INIT;
        end else if (enable) begin
            r_crc <= w_fold;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/usb_tx_sequencer.sv
// rtl/usb_tx_sequencer.sv - sequences SYNC/PID/payload/CRC16/EOP for one USB FS packet per command
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64
)
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic [7:0] enc_byte,
    output logic       enc_valid,
    input  logic       enc_ready,
    output logic       enc_eop,
    input  logic       enc_eop_done
);

    tx_state_t   r_state;
    tx_cmd_t     r_cmd;
    logic [6:0]  r_len;
    logic [7:0]  r_enc_byte;
    logic        r_enc_valid;
    logic        r_enc_eop;
    logic        r_get;
    logic        r_active;
    logic        r_error;

    tx_cmd_t     w_cmd;
    logic        w_hs;
    logic        w_len_err;
    logic [15:0] w_crc;
    logic        w_crc_clear;
    logic        w_crc_enable;

    assign w_cmd        = tx_cmd_t'(tx_packet);
    assign w_hs         = r_enc_valid & enc_ready;
    assign w_len_err    = is_data_cmd(w_cmd) && (buffer_occupancy > 7'(MAX_PAYLOAD));
    assign w_crc_clear  = (r_state == ST_IDLE);
    assign w_crc_enable = (r_state == ST_LOAD);

    usb_crc16 u_crc (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (w_crc_clear),
        .enable (w_crc_enable),
        .data   (tx_packet_data),
        .crc    (w_crc)
    );

    // Packet sequencer; every output is a register updated on the transition that needs it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= CMD_NONE;
            r_len       <= 7'd0;
            r_enc_byte  <= 8'h00;
            r_enc_valid <= 1'b0;
            r_enc_eop   <= 1'b0;
            r_get       <= 1'b0;
            r_active    <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd != CMD_NONE) begin
                        r_cmd    <= w_cmd;
                        r_len    <= buffer_occupancy;
                        r_active <= 1'b1;
                        if (is_invalid_cmd(w_cmd) || w_len_err) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state     <= ST_SYNC;
                            r_enc_valid <= 1'b1;
                            r_enc_byte  <= SYNC_BYTE;
                        end
                    end
                end
                ST_SYNC: begin
                    if (w_hs) begin
                        r_state    <= ST_PID;
                        r_enc_byte <= pid_byte(r_cmd);
                    end
                end
                ST_PID: begin
                    if (w_hs) begin
                        if (!is_data_cmd(r_cmd)) begin
                            r_state     <= ST_EOP;
                            r_enc_valid <= 1'b0;
                            r_enc_eop   <= 1'b1;
                        end else if (r_len != 7'd0) begin
                            r_state     <= ST_FETCH;
                            r_enc_valid <= 1'b0;
                            r_get       <= 1'b1;
                        end else begin
                            // Empty payload: CRC is still the seed, so this sends 00 00
                            r_state    <= ST_CRC_LO;
                            r_enc_byte <= ~w_crc[7:0];
                        end
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_LOAD;
                    r_get   <= 1'b0;
                end
                ST_LOAD: begin
                    // Buffer data is valid this cycle; the CRC block folds the same byte now
                    r_state     <= ST_SEND;
                    r_enc_byte  <= tx_packet_data;
                    r_len       <= r_len - 7'd1;
                    r_enc_valid <= 1'b1;
                end
                ST_SEND: begin
                    if (w_hs) begin
                        if (r_len != 7'd0) begin
                            r_state     <= ST_FETCH;
                            r_enc_valid <= 1'b0;
                            r_get       <= 1'b1;
                        end else begin
                            r_state    <= ST_CRC_LO;
                            r_enc_byte <= ~w_crc[7:0];
                        end
                    end
                end
                ST_CRC_LO: begin
                    if (w_hs) begin
                        r_state    <= ST_CRC_HI;
                        r_enc_byte <= ~w_crc[15:8];
                    end
                end
                ST_CRC_HI: begin
                    if (w_hs) begin
                        r_state     <= ST_EOP;
                        r_enc_valid <= 1'b0;
                        r_enc_eop   <= 1'b1;
                    end
                end
                ST_EOP: begin
                    if (enc_eop_done) begin
                        r_state   <= ST_DONE;
                        r_enc_eop <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_WAIT_CLR;
                    r_active <= 1'b0;
                end
                ST_ERROR: begin
                    r_state  <= ST_WAIT_CLR;
                    r_error  <= 1'b0;
                    r_active <= 1'b0;
                end
                ST_WAIT_CLR: begin
                    // Hold off until the slave has visibly cleared the command register
                    if (w_cmd == CMD_NONE) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_enc_valid <= 1'b0;
                    r_enc_eop   <= 1'b0;
                    r_get       <= 1'b0;
                    r_active    <= 1'b0;
                    r_error     <= 1'b0;
                end
            endcase
        end
    end

    assign get_tx_packet_data = r_get;
    assign tx_transfer_active = r_active;
    assign tx_error           = r_error;
    assign enc_byte           = r_enc_byte;
    assign enc_valid          = r_enc_valid;
    assign enc_eop            = r_enc_eop;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// tb/tb_usb_tx_sequencer.sv - scoreboard bench for usb_tx_sequencer
module tb_usb_tx_sequencer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] tx_packet = 3'd0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [7:0] tx_packet_data = 8'h00;
    logic       get_tx_packet_data;
    logic       tx_transfer_active;
    logic       tx_error;
    logic [7:0] enc_byte;
    logic       enc_valid;
    logic       enc_ready = 1'b0;
    logic       enc_eop;
    logic       enc_eop_done = 1'b0;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem [0:15];
    int         rd_idx = 0;
    int         pop_cnt = 0;
    int         err_cycles = 0;
    int         err_inactive = 0;
    int         valid_seen = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    usb_tx_sequencer #(.MAX_PAYLOAD(64)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .enc_byte           (enc_byte),
        .enc_valid          (enc_valid),
        .enc_ready          (enc_ready),
        .enc_eop            (enc_eop),
        .enc_eop_done       (enc_eop_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Data buffer: the byte appears one cycle after the pop strobe
    always @(posedge clk) begin
        if (n_rst && get_tx_packet_data) begin
            #1;
            tx_packet_data = mem[rd_idx[3:0]];
            rd_idx++;
        end
    end

    // Monitor: compares every encoder transfer against the scoreboard queue
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (get_tx_packet_data) pop_cnt++;
            if (tx_error) begin
                err_cycles++;
                if (!tx_transfer_active) err_inactive++;
            end
            if (enc_valid) valid_seen++;
            if (enc_eop) check("valid_low_in_eop", 32'(enc_valid), 32'd0);
            if (prev_stall) begin
                check("stall_valid_held", 32'(enc_valid), 32'd1);
                check("stall_byte_stable", 32'(enc_byte), 32'(prev_byte));
            end
            if (enc_valid && enc_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none", enc_byte);
                end else begin
                    check("enc_byte", 32'(enc_byte), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = enc_valid && !enc_ready;
            prev_byte  = enc_byte;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] crc_usb(input int n);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            b = mem[i % 16];
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ b[j]) c = (c >> 1) ^ 16'hA001;
                else             c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic push_data_pkt(input logic [7:0] pid, input int n);
        logic [15:0] c;
        c = crc_usb(n);
        exp_q.push_back(8'h80);
        exp_q.push_back(pid);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[i % 16]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
    endtask

    task automatic run_pkt(input logic [2:0] cmd, input logic [6:0] occ, input int exp_pops,
                           input logic [15:0] rdy_pat);
        int cyc;
        pop_cnt = 0;
        rd_idx  = 0;
        tick();
        tx_packet        = cmd;
        buffer_occupancy = occ;
        enc_ready        = rdy_pat[0];
        tick();
        buffer_occupancy = 7'd0;
        cyc = 0;
        while (!enc_eop && cyc < 400) begin
            enc_ready = rdy_pat[cyc[3:0]];
            tick();
            cyc++;
        end
        check("eop_reached", 32'(enc_eop), 32'd1);
        repeat (3) tick();
        check("eop_held", 32'(enc_eop), 32'd1);
        enc_eop_done = 1'b1;
        tick();
        enc_eop_done = 1'b0;
        check("done_active", 32'(tx_transfer_active), 32'd1);
        check("eop_released", 32'(enc_eop), 32'd0);
        repeat (4) tick();
        check("wait_clr_inactive", 32'(tx_transfer_active), 32'd0);
        check("wait_clr_no_valid", 32'(enc_valid), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("pop_count", 32'(pop_cnt), 32'(exp_pops));
        tx_packet = 3'd0;
        repeat (2) tick();
    endtask

    task automatic run_err(input logic [2:0] cmd, input logic [6:0] occ);
        err_cycles   = 0;
        err_inactive = 0;
        valid_seen   = 0;
        pop_cnt      = 0;
        tick();
        tx_packet        = cmd;
        buffer_occupancy = occ;
        repeat (6) tick();
        check("err_pulse_len", 32'(err_cycles), 32'd1);
        check("err_with_active", 32'(err_inactive), 32'd0);
        check("err_no_valid", 32'(valid_seen), 32'd0);
        check("err_no_pops", 32'(pop_cnt), 32'd0);
        check("err_wait_inactive", 32'(tx_transfer_active), 32'd0);
        tx_packet        = 3'd0;
        buffer_occupancy = 7'd0;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        #1;
        check("rst_valid", 32'(enc_valid), 32'd0);
        check("rst_byte", 32'(enc_byte), 32'd0);
        check("rst_eop", 32'(enc_eop), 32'd0);
        check("rst_get", 32'(get_tx_packet_data), 32'd0);
        check("rst_active", 32'(tx_transfer_active), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        // ACK: SYNC + PID only, held in WAIT_CLR while command stays set
        exp_q.push_back(8'h80); exp_q.push_back(8'hD2);
        run_pkt(3'd3, 7'd0, 0, 16'hFFFF);

        // NAK with large occupancy: handshake packets never pop or length-check
        exp_q.push_back(8'h80); exp_q.push_back(8'h5A);
        run_pkt(3'd4, 7'd100, 0, 16'hFFFF);

        exp_q.push_back(8'h80); exp_q.push_back(8'h1E);
        run_pkt(3'd5, 7'd0, 0, 16'hFFFF);

        // DATA0 "123456789": CRC-16/USB check value 0xB4C8
        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        exp_q.push_back(8'h80); exp_q.push_back(8'hC3);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
        exp_q.push_back(8'hC8); exp_q.push_back(8'hB4);
        run_pkt(3'd1, 7'd9, 9, 16'hFFFF);

        // DATA1 zero-length
        exp_q.push_back(8'h80); exp_q.push_back(8'h4B);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        run_pkt(3'd2, 7'd0, 0, 16'hFFFF);

        run_err(3'd6, 7'd0);
        run_err(3'd7, 7'd0);
        run_err(3'd1, 7'd65);

        // DATA1 at the maximum payload of 64 bytes
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 7 + 1);
        push_data_pkt(8'h4B, 64);
        run_pkt(3'd2, 7'd64, 64, 16'hFFFF);

        // Backpressure on a 4-byte DATA0
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hFF;
        push_data_pkt(8'hC3, 4);
        run_pkt(3'd1, 7'd4, 4, 16'b1011_0010_0110_1001);

        // Reset while payload byte 2 is presented and stalled
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        pop_cnt = 0;
        rd_idx  = 0;
        exp_q.push_back(8'h80); exp_q.push_back(8'hC3); exp_q.push_back(8'h11);
        tick();
        tx_packet        = 3'd1;
        buffer_occupancy = 7'd4;
        enc_ready        = 1'b1;
        cyc = 0;
        while (!(pop_cnt == 2 && enc_valid) && cyc < 50) begin
            tick();
            cyc++;
        end
        enc_ready = 1'b0;
        check("send2_byte", 32'(enc_byte), 32'h22);
        #2 n_rst = 1'b0;
        #1;
        check("arst_valid", 32'(enc_valid), 32'd0);
        check("arst_byte", 32'(enc_byte), 32'd0);
        check("arst_eop", 32'(enc_eop), 32'd0);
        check("arst_get", 32'(get_tx_packet_data), 32'd0);
        check("arst_active", 32'(tx_transfer_active), 32'd0);
        check("arst_error", 32'(tx_error), 32'd0);
        check("arst_bytes_sent", 32'(exp_q.size()), 32'd0);
        check("arst_pops", 32'(pop_cnt), 32'd2);
        exp_q.delete();
        tx_packet        = 3'd0;
        buffer_occupancy = 7'd0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        exp_q.push_back(8'h80); exp_q.push_back(8'hD2);
        run_pkt(3'd3, 7'd0, 0, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
